// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte streams,
// round-robin between messages, locked to one requester within a message.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_wr,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [2:0]           grant_id,
  output logic                 locked,
  output logic                 lock_timeout
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [15:0] TC = 16'(LOCK_TIMEOUT - 1);
  state_t      state;
  logic [15:0] cnt;
  logic [7:0]  vpad, lpad;
  logic [63:0] dpad;
  logic [3:0]  s;
  logic [2:0]  rr, win;
  logic        go;
  assign vpad = 8'(req_valid);
  assign lpad = 8'(req_last);
  assign dpad = 64'(req_data);
  // descending scan so the nearest requester after grant_id is written last
  always_comb begin
    s  = '0;
    rr = grant_id;
    for (int k = NUM_REQ - 1; k >= 1; k--) begin
      s = {1'b0, grant_id} + 4'(k);
      s = (s >= 4'(NUM_REQ)) ? s - 4'(NUM_REQ) : s;
      if (vpad[s[2:0]]) rr = s[2:0];
    end
    win = locked ? grant_id : rr;
    go  = state == IDLE && !tx_busy && vpad[win];
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      req_ready    <= '0;
      tx_data      <= '0;
      tx_wr        <= 1'b0;
      grant_id     <= 3'(NUM_REQ - 1);
      locked       <= 1'b0;
      lock_timeout <= 1'b0;
      cnt          <= '0;
    end else begin
      req_ready    <= '0;
      tx_wr        <= 1'b0;
      lock_timeout <= 1'b0;
      if (state == WAIT) begin
        if (tx_done) state <= IDLE;
      end else if (go) begin
        tx_data   <= dpad[{win, 3'b000} +: 8];
        tx_wr     <= 1'b1;
        req_ready <= NUM_REQ'(8'd1 << win);
        grant_id  <= win;
        locked    <= ~lpad[win];
        cnt       <= '0;
        state     <= WAIT;
      end else if (locked && !vpad[grant_id]) begin
        if (LOCK_TIMEOUT != 0 && cnt == TC) begin
          locked       <= 1'b0;
          lock_timeout <= 1'b1;
          cnt          <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: message-level round-robin reference model with a
// behavioural transceiver, plus directed lock, busy and reset scenarios.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  logic          sys_clk, sys_rst_n;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic [7:0]    tx_data;
  logic          tx_wr, tx_busy, tx_done;
  logic [2:0]    grant_id;
  logic          locked, lock_timeout;
  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(10)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid),
    .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .locked(locked), .lock_timeout(lock_timeout)
  );
  int checks = 0, errors = 0;
  logic [8:0]  rq [NR][$];
  logic [8:0]  mq [NR][$];
  logic [11:0] expq [$];
  logic [NR-1:0] adv;
  int  mptr, xrem;
  logic xbusy;
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic build_expected();
    int found;
    logic [8:0] b;
    for (int i = 0; i < NR; i++) mq[i] = rq[i];
    while (1) begin
      found = -1;
      for (int k = 1; k <= NR; k++)
        if (found < 0 && mq[(mptr + k) % NR].size() != 0) found = (mptr + k) % NR;
      if (found < 0) break;
      do begin
        b = mq[found].pop_front();
        expq.push_back({3'(found), b});
      end while (!b[8] && mq[found].size() != 0);
      mptr = found;
    end
  endtask
  task automatic tick_auto();
    logic [11:0] e;
    logic [8:0] h;
    @(negedge sys_clk);
    tx_done = 1'b0;
    for (int i = 0; i < NR; i++) if (adv[i]) begin void'(rq[i].pop_front()); adv[i] = 1'b0; end
    for (int i = 0; i < NR; i++) if (req_ready[i]) adv[i] = 1'b1;
    if (lock_timeout) check("no_timeout", 32'(lock_timeout), 0);
    if (tx_wr) begin
      check("wr_idle", 32'(xbusy), 0);
      check("wr_expected", 32'(expq.size() != 0), 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("tx_data", 32'(tx_data), 32'(e[7:0]));
        check("grant", 32'(grant_id), 32'(e[11:9]));
        check("ready", 32'(req_ready), 32'(1) << e[11:9]);
        check("locked", 32'(locked), 32'(!e[8]));
      end
      xbusy = 1'b1; tx_busy = 1'b1; xrem = $urandom_range(1, 4);
    end else if (xbusy) begin
      xrem--;
      if (xrem == 0) begin xbusy = 1'b0; tx_busy = 1'b0; tx_done = 1'b1; end
    end
    for (int i = 0; i < NR; i++)
      if (rq[i].size() != 0) begin
        h = rq[i][0];
        req_valid[i] = 1'b1; req_data[8*i +: 8] = h[7:0]; req_last[i] = h[8];
      end else req_valid[i] = 1'b0;
  endtask
  function automatic logic pend();
    pend = adv != 0;
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) pend = 1'b1;
  endfunction
  task automatic run_traffic(input int budget);
    int n = 0;
    while ((expq.size() != 0 || pend() || xbusy || tx_done) && n < budget) begin
      tick_auto();
      n++;
    end
    check("drain_exp", 32'(expq.size()), 0);
    check("drain_req", 32'(pend()), 0);
  endtask
  initial begin
    int first_to, first_wr, nm, len;
    logic lk, saw;
    logic [2:0] g;
    logic [7:0] d;
    sys_rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    tx_busy = 1'b0; tx_done = 1'b0; xbusy = 1'b0; adv = '0; xrem = 0;
    rq[0] = '{9'h1A0, 9'h1B0}; rq[1] = '{9'h1A1}; rq[2] = '{9'h1A2}; rq[3] = '{9'h1A3, 9'h1B3};
    mptr = NR - 1;
    build_expected();
    repeat (3) tick_auto();
    check("rst_ready", 32'(req_ready), 0);
    check("rst_wr", 32'(tx_wr), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_grant", 32'(grant_id), NR - 1);
    check("rst_locked", 32'(locked), 0);
    check("rst_timeout", 32'(lock_timeout), 0);
    sys_rst_n = 1'b1;
    tick_auto();
    check("rst_first_wr", 32'(tx_wr), 1);
    check("rst_first_ready", 32'(req_ready), 1);
    run_traffic(2000);
    rq[0] = '{9'h041, 9'h042, 9'h143}; rq[2] = '{9'h15A};
    build_expected();
    run_traffic(2000);
    @(negedge sys_clk);
    req_valid = 4'b0010; req_data[15:8] = 8'h11; req_last = 4'b0000;
    @(negedge sys_clk);
    check("to_wr", 32'(tx_wr), 1);
    check("to_grant1", 32'(grant_id), 1);
    check("to_locked", 32'(locked), 1);
    @(negedge sys_clk);
    req_valid = 4'b1000; req_data[31:24] = 8'h33; req_last = 4'b1000; tx_busy = 1'b1;
    @(negedge sys_clk);
    tx_busy = 1'b0; tx_done = 1'b1;
    @(negedge sys_clk);
    tx_done = 1'b0;
    first_to = -1; first_wr = -1; lk = 1'b1; g = '0; d = '0;
    for (int k = 0; k < 16 && first_wr < 0; k++) begin
      if (k > 0) @(negedge sys_clk);
      if (lock_timeout && first_to < 0) begin first_to = k; lk = locked; end
      if (tx_wr) begin first_wr = k; g = grant_id; d = tx_data; end
    end
    check("to_cycle", 32'(first_to), 10);
    check("to_unlock", 32'(lk), 0);
    check("to_next_wr", 32'(first_wr), 11);
    check("to_grant3", 32'(g), 3);
    check("to_data", 32'(d), 32'h33);
    @(negedge sys_clk);
    req_valid = '0; req_last = '0; tx_done = 1'b1;
    @(negedge sys_clk);
    tx_done = 1'b0;
    tx_busy = 1'b1; req_valid = 4'b0001; req_data[7:0] = 8'h5C; req_last = 4'b0001;
    saw = 1'b0;
    repeat (5) begin @(negedge sys_clk); saw |= tx_wr; end
    check("busy_hold", 32'(saw), 0);
    tx_busy = 1'b0;
    @(negedge sys_clk);
    check("busy_wr", 32'(tx_wr), 1);
    check("busy_grant", 32'(grant_id), 0);
    @(negedge sys_clk);
    req_valid = '0; req_last = '0; tx_done = 1'b1;
    @(negedge sys_clk);
    tx_done = 1'b0;
    mptr = 0;
    repeat (4) begin
      for (int i = 0; i < NR; i++) begin
        nm = $urandom_range(0, 3);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) rq[i].push_back({b == len - 1, 8'($urandom)});
        end
      end
      build_expected();
      run_traffic(6000);
    end
    @(negedge sys_clk);
    req_valid = 4'b0100; req_data[23:16] = 8'h77; req_last = 4'b0000;
    @(negedge sys_clk);
    check("ar_wr", 32'(tx_wr), 1);
    check("ar_locked", 32'(locked), 1);
    #1 sys_rst_n = 1'b0;
    #1;
    check("ar_wr0", 32'(tx_wr), 0);
    check("ar_ready0", 32'(req_ready), 0);
    check("ar_locked0", 32'(locked), 0);
    check("ar_grant", 32'(grant_id), NR - 1);
    check("ar_data", 32'(tx_data), 0);
    check("ar_timeout", 32'(lock_timeout), 0);
    req_valid = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("ar_after_wr", 32'(tx_wr), 0);
    check("ar_after_lock", 32'(locked), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
